ising_jmem_arbiter: RTL

ISING_JMEM_ARBITER -- requirements
Module: ising_jmem_arbiter

---
 rtl/ising_jmem_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ising_jmem_arbiter.sv
// Ising J-memory read arbiter.
// Shares one read-only J-memory port between the spin-load path and the
// compute path. The effective mode selects which paths may issue. A mode
// change is applied only after every issued read has been answered. Responses
// come back in order, and a small tag FIFO records which path owns each one.
module ising_jmem_arbiter #(
  parameter int AddrWidth      = 8,
  parameter int DataWidth      = 256,
  parameter int MaxOutstanding = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [1:0]           mode_i,
  input  logic                 ld_req_i,
  input  logic [AddrWidth-1:0] ld_addr_i,
  output logic                 ld_gnt_o,
  output logic                 ld_rvalid_o,
  output logic [DataWidth-1:0] ld_rdata_o,
  input  logic                 cp_req_i,
  input  logic [AddrWidth-1:0] cp_addr_i,
  output logic                 cp_gnt_o,
  output logic                 cp_rvalid_o,
  output logic [DataWidth-1:0] cp_rdata_o,
  output logic                 mem_q_valid_o,
  output logic [AddrWidth-1:0] mem_q_addr_o,
  input  logic                 mem_q_ready_i,
  input  logic                 mem_p_valid_i,
  input  logic [DataWidth-1:0] mem_p_data_i,
  output logic [1:0]           mode_o,
  output logic                 draining_o,
  output logic                 err_o
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  localparam logic [1:0] MODE_LOAD    = 2'd0;
  localparam logic [1:0] MODE_COMPUTE = 2'd1;
  localparam logic [1:0] MODE_SHARED  = 2'd2;
  localparam logic [1:0] MODE_HALT    = 2'd3;

  // Tag value stored per outstanding read: which path owns the response.
  localparam logic TAG_LD = 1'b0;
  localparam logic TAG_CP = 1'b1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              state_reg, state_next;
  logic [1:0]          mode_reg, mode_next;
  logic                last_cp_reg;
  logic                err_reg;
  logic [CntW-1:0]     count_reg;
  logic [PtrW-1:0]     wr_ptr_reg;
  logic [PtrW-1:0]     rd_ptr_reg;
  logic                tag_reg [MaxOutstanding];
  logic [MaxOutstanding-1:0] tag_we;

  logic mode_match;
  logic ld_elig;
  logic cp_elig;
  logic sel_valid;
  logic sel_cp;
  logic fifo_empty;
  logic fifo_not_full;
  logic q_valid;
  logic grant;
  logic pop;
  logic head_tag;

  // Wrap-around increment for the tag FIFO pointers (depth need not be 2^n).
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxOutstanding - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Request eligibility and round-robin selection between the two paths.
  always_comb begin
    mode_match    = (mode_i == mode_reg);
    ld_elig       = ld_req_i & ((mode_reg == MODE_LOAD) | (mode_reg == MODE_SHARED));
    cp_elig       = cp_req_i & ((mode_reg == MODE_COMPUTE) | (mode_reg == MODE_SHARED));
    sel_valid     = ld_elig | cp_elig;
    // On a tie, compute wins only when load was granted last.
    sel_cp        = cp_elig & (~ld_elig | ~last_cp_reg);
    fifo_empty    = (count_reg == '0);
    fifo_not_full = (count_reg < CntW'(MaxOutstanding));
    head_tag      = tag_reg[rd_ptr_reg];
    // Issue is withheld in reset so no grant can leak while state clears.
    q_valid       = ~rst_i & (state_reg == ST_RUN) & mode_match & sel_valid & fifo_not_full;
    grant         = q_valid & mem_q_ready_i;
    pop           = ~rst_i & mem_p_valid_i & ~fifo_empty;
  end

  // FSM state register together with the effective mode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_RUN;
      mode_reg  <= MODE_HALT;
    end else begin
      state_reg <= state_next;
      mode_reg  <= mode_next;
    end
  end

  // FSM next state: drain on any mode request change, adopt the new mode once idle.
  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    case (state_reg)
      ST_RUN: begin
        if (!mode_match) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_next = ST_RUN;
          mode_next  = mode_i;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // FSM outputs: memory request, grants and response steering.
  always_comb begin
    draining_o    = (state_reg == ST_DRAIN);
    mode_o        = mode_reg;
    err_o         = err_reg;
    mem_q_valid_o = q_valid;
    mem_q_addr_o  = '0;
    if (q_valid) begin
      mem_q_addr_o = sel_cp ? cp_addr_i : ld_addr_i;
    end
    ld_gnt_o      = grant & ~sel_cp;
    cp_gnt_o      = grant & sel_cp;
    ld_rvalid_o   = pop & (head_tag == TAG_LD);
    cp_rvalid_o   = pop & (head_tag == TAG_CP);
    ld_rdata_o    = mem_p_data_i;
    cp_rdata_o    = mem_p_data_i;
  end

  // Per-entry write enables for the tag FIFO storage.
  generate
    for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_tag_we
      assign tag_we[gi] = grant & (wr_ptr_reg == PtrW'(gi));
    end
  endgenerate

  // Tag FIFO storage: records the owner of each issued read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        tag_reg[i] <= TAG_LD;
      end
    end else begin
      for (int i = 0; i < MaxOutstanding; i++) begin
        if (tag_we[i]) begin
          tag_reg[i] <= sel_cp;
        end
      end
    end
  end

  // Tag FIFO pointers and occupancy (occupancy is the outstanding-read count).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (grant) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({grant, pop})
        2'b10:   count_reg <= count_reg + CntW'(1);
        2'b01:   count_reg <= count_reg - CntW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Round-robin pointer: remembers which path won the last actual grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_cp_reg <= 1'b1;
    end else if (grant) begin
      last_cp_reg <= sel_cp;
    end
  end

  // Sticky error: a response arrived with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_reg <= 1'b0;
    end else if (mem_p_valid_i && fifo_empty) begin
      err_reg <= 1'b1;
    end
  end

endmodule
